// File: rtl/tone_pkg.sv
// Shared constants for the multi-channel tone generator: register map helpers,
// control bit positions and the noise LFSR definition.
package tone_pkg;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_NOISE = 1;

    localparam int          LFSR_W     = 15;
    localparam logic [14:0] LFSR_SEED  = 15'h0001;
    localparam int          LFSR_TAP_A = 14;
    localparam int          LFSR_TAP_B = 13;

    // The control nibble sits directly above the period nibbles.
    function automatic logic [2:0] sel_ctrl(input int pw);
        return 3'(pw / 4);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: nibble-written period, control bits, tick counter and output.
// Noise mode (15-bit LFSR) is only built when TONE_NOISE_EN is defined.
module tone_channel
    import tone_pkg::*;
#(
    parameter int PW = 12
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_we,
    input  logic [2:0] i_sel,
    input  logic [3:0] i_din,
    output logic       o_sout
);

    localparam int         NNIB     = PW / 4;
    localparam logic [2:0] SEL_CTRL = sel_ctrl(PW);

    logic [PW-1:0] r_period;
    logic [PW-1:0] r_cnt;
    logic          r_en;
    logic          r_sout;
    logic          w_ctrl_we;
    logic          w_dis;

    assign w_ctrl_we = i_we && (i_sel == SEL_CTRL);
    assign w_dis     = w_ctrl_we && !i_din[CTRL_EN];

`ifdef TONE_NOISE_EN
    logic              r_noise;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;

    assign w_lfsr_next = {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
`endif

    // Counter logic reads only pre-write state; a disabling write wins over an event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_sout   <= 1'b0;
`ifdef TONE_NOISE_EN
            r_noise  <= 1'b0;
            r_lfsr   <= LFSR_SEED;
`endif
        end else begin
            if (i_we) begin
                for (int k = 0; k < NNIB; k++) begin
                    if (i_sel == 3'(k)) r_period[4*k +: 4] <= i_din;
                end
            end
            if (w_ctrl_we) begin
                r_en    <= i_din[CTRL_EN];
`ifdef TONE_NOISE_EN
                r_noise <= i_din[CTRL_NOISE];
`endif
            end

            if (!r_en || w_dis) begin
                r_cnt  <= '0;
                r_sout <= 1'b0;
`ifdef TONE_NOISE_EN
                r_lfsr <= LFSR_SEED;
`endif
            end else if (r_period == '0) begin
                r_cnt  <= '0;
                r_sout <= 1'b0;
            end else if (i_tick) begin
                if (r_cnt >= r_period) begin
                    r_cnt <= '0;
`ifdef TONE_NOISE_EN
                    if (r_noise) begin
                        r_lfsr <= w_lfsr_next;
                        r_sout <= w_lfsr_next[0];
                    end else begin
                        r_sout <= ~r_sout;
                    end
`else
                    r_sout <= ~r_sout;
`endif
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_sout = r_sout;

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator: shared prescaler, write decode,
// NCH tone_channel instances and a registered popcount mix. Option: TONE_NOISE_EN.
module tone_gen_multi
    import tone_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int PW       = 12,
    parameter int PRESCALE = 16
) (
    input  logic           CLK,
    input  logic           RST_C,
    input  logic           WE,
    input  logic [1:0]     CH,
    input  logic [2:0]     SEL,
    input  logic [3:0]     DIN,
    output logic [NCH-1:0] SOUT,
    output logic [2:0]     MIX
);

    localparam int PSW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PSW-1:0] r_presc;
    logic           w_tick;
    logic [NCH-1:0] w_sout;
    logic [3:0]     w_sout4;
    logic [2:0]     r_mix;

    assign w_tick = (r_presc == PSW'(PRESCALE - 1));

    // Free-running; writes never disturb the tick phase.
    always_ff @(posedge CLK or negedge RST_C) begin
        if (!RST_C) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic w_we;
        assign w_we = WE && (CH == 2'(g));

        tone_channel #(
            .PW (PW)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst_n (RST_C),
            .i_tick  (w_tick),
            .i_we    (w_we),
            .i_sel   (SEL),
            .i_din   (DIN),
            .o_sout  (w_sout[g])
        );
    end

    always_comb begin
        w_sout4             = '0;
        w_sout4[NCH-1:0]    = w_sout;
    end

    always_ff @(posedge CLK or negedge RST_C) begin
        if (!RST_C) begin
            r_mix <= '0;
        end else begin
            r_mix <= popcount4(w_sout4);
        end
    end

    assign SOUT = w_sout;
    assign MIX  = r_mix;

endmodule
